normalize_sub: RTL and testbench

- Post-subtraction normaliser for the FP ALU subtract path. It is the left-shift counterpart of the right-shifting alignment register.
- Takes the raw mantissa difference, which may have leading zeros, and the provisional result exponent.
- Shifts the mantissa left one bit per clock, shifting in 0s, and decrements the exponent each shift.
- Stops when the mantissa MSB is 1, the mantissa is zero, or the exponent floor is reached. Then presents the normalised result with a one-cycle done pulse.

---
 rtl/normalize_sub_pkg.sv | 16 +
 rtl/normalize_sub.sv | 97 +++++++++
 tb/tb_normalize_sub.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/normalize_sub_pkg.sv
// Shared FP ALU definitions: widths, FSM encoding, exponent floor.
// Used by the alignment shifter and the subtract-path normaliser.
package normalize_sub_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int CNT_W_DEF  = 5;
  localparam int EXP_MIN    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

endpackage

// File: rtl/normalize_sub.sv
// Sequential left-shift normaliser for the FP subtract path.
// One bit per clock until MSB set, mantissa zero, or exponent floor.
module normalize_sub
  import normalize_sub_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [MANT_W-1:0] m_in,
  input  logic [EXP_W-1:0]  e_in,
  output logic [MANT_W-1:0] m_out,
  output logic [EXP_W-1:0]  e_out,
  output logic [CNT_W-1:0]  shamt,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic              underflow
);

  norm_state_e       state_q, state_d;
  logic [MANT_W-1:0] m_q, m_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [CNT_W-1:0]  sh_q, sh_d;
  logic              zero_q, zero_d;
  logic              uf_q, uf_d;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    sh_d    = sh_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          m_d     = m_in;
          e_d     = e_in;
          sh_d    = '0;
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // zero and normalised checks outrank the exponent floor
        if (m_q == '0) begin
          e_d     = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (m_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (e_q <= EXP_W'(EXP_MIN)) begin
          uf_d    = 1'b1;
          state_d = DONE;
        end else begin
          m_d  = {m_q[MANT_W-2:0], 1'b0};
          e_d  = e_q - EXP_W'(1);
          sh_d = sh_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      sh_q    <= '0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      sh_q    <= sh_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
    end
  end

  assign m_out     = m_q;
  assign e_out     = e_q;
  assign shamt     = sh_q;
  assign zero      = zero_q;
  assign underflow = uf_q;
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_normalize_sub.sv
// Scoreboard bench for normalize_sub: directed vectors,
// expected results queued at issue, checked by a done monitor.
module tb_normalize_sub;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int CW = 5;

  typedef struct {
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    logic [CW-1:0] sh;
    logic          z;
    logic          uf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [MW-1:0] m_in;
  logic [EW-1:0] e_in;
  logic [MW-1:0] m_out;
  logic [EW-1:0] e_out;
  logic [CW-1:0] shamt;
  logic          busy;
  logic          done;
  logic          zero;
  logic          underflow;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  normalize_sub #(.MANT_W(MW), .EXP_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .load(load),
    .m_in(m_in), .e_in(e_in),
    .m_out(m_out), .e_out(e_out), .shamt(shamt),
    .busy(busy), .done(done), .zero(zero),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      exp_t x;
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        x = sb.pop_front();
        chk("m_out", 32'(m_out), 32'(x.m));
        chk("e_out", 32'(e_out), 32'(x.e));
        chk("shamt", 32'(shamt), 32'(x.sh));
        chk("zero", 32'(zero), 32'(x.z));
        chk("underflow", 32'(underflow), 32'(x.uf));
      end
    end
  end

  task automatic push(input logic [MW-1:0] m, input logic [EW-1:0] e,
                      input logic [CW-1:0] sh, input logic z,
                      input logic uf);
    exp_t x;
    x.m = m; x.e = e; x.sh = sh; x.z = z; x.uf = uf;
    sb.push_back(x);
  endtask

  task automatic start(input logic [MW-1:0] m, input logic [EW-1:0] e);
    @(negedge clk);
    load = 1'b1; m_in = m; e_in = e;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts busy cycles until done; starts on the first SHIFT cycle.
  task automatic wait_done(input string nm, input int exp_busy,
                           input int pre);
    int nb;
    bit seen;
    nb = pre;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end
    chk({nm, "_busy"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; m_in = '0; e_in = '0;
    #12;
    chk("rst_m", 32'(m_out), 0);
    chk("rst_e", 32'(e_out), 0);
    chk("rst_sh", 32'(shamt), 0);
    chk("rst_flags", {28'd0, busy, done, zero, underflow}, 0);
    @(negedge clk);
    reset = 1'b1;

    push(24'h800000, 8'h80, 5'd0, 1'b0, 1'b0);
    start(24'h800000, 8'h80);
    wait_done("norm", 1, 0);

    push(24'h800000, 8'h69, 5'd23, 1'b0, 1'b0);
    start(24'h000001, 8'h80);
    wait_done("max", 24, 0);

    push(24'h000000, 8'h00, 5'd0, 1'b1, 1'b0);
    start(24'h000000, 8'h45);
    wait_done("zero", 1, 0);

    push(24'h010000, 8'h01, 5'd4, 1'b0, 1'b1);
    start(24'h001000, 8'h05);
    wait_done("uflow", 5, 0);

    push(24'h400000, 8'h00, 5'd0, 1'b0, 1'b1);
    start(24'h400000, 8'h00);
    wait_done("e0", 1, 0);

    push(24'h800000, 8'h01, 5'd0, 1'b0, 1'b0);
    start(24'h800000, 8'h01);
    wait_done("norm_e1", 1, 0);

    push(24'h800000, 8'h81, 5'd15, 1'b0, 1'b0);
    start(24'h000100, 8'h90);
    repeat (3) @(negedge clk);
    load = 1'b1; m_in = 24'hFFFFFF; e_in = 8'h10;
    @(negedge clk);
    load = 1'b0;
    wait_done("busyload", 16, 4);

    start(24'h000001, 8'h80);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_m", 32'(m_out), 0);
    chk("midrst_e", 32'(e_out), 0);
    chk("midrst_sh", 32'(shamt), 0);
    chk("midrst_flags", {28'd0, busy, done, zero, underflow}, 0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int dc;
      dc = done_cnt;
      repeat (30) @(negedge clk);
      chk("no_done_after_rst", 32'(done_cnt), 32'(dc));
      chk("idle_after_rst", 32'(busy), 0);
    end

    push(24'hC00000, 8'h7E, 5'd2, 1'b0, 1'b0);
    start(24'h300000, 8'h80);
    wait_done("post_rst", 3, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
